rr_stream_mux: RTL and testbench

- Parametrised N:1 multiplexer with valid/ready handshakes, built-in round-robin arbitration and one registered output stage.
- Replaces the fixed-select mux2/mux4/mux8 style wherever several producers share one consumer, for example memory-request merging or writeback-port sharing.
- Select is generated internally and fair; the chosen channel index is reported with the data.

---
 rtl/rr_stream_mux_pkg.sv | 24 ++
 rtl/rr_stream_mux_arbiter.sv | 35 +++
 rtl/rr_stream_mux.sv | 139 +++++++++++++
 tb/tb_rr_stream_mux.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared types and helpers for rr_stream_mux.
//   lock_state_e   : packet-lock state (only used when STREAM_MUX_LOCK_EN is defined)
//   outreg_state_e : occupancy of the single output register
//   MAX_NUM_IN     : largest supported channel count
//   next_ptr()     : round-robin pointer increment modulo n
package rr_stream_mux_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outreg_state_e;

    localparam int MAX_NUM_IN = 16;

    function automatic int unsigned next_ptr(input int unsigned p, input int unsigned n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter: purely combinational round-robin grant.
// Scans req starting at ptr, wrapping modulo NUM_IN, and grants the first
// requester found.
//   req       : request vector, bit i = channel i
//   ptr       : channel with highest priority this cycle
//   grant     : one-hot grant (all-zero when nothing requests)
//   grant_idx : index of the granted channel (0 when nothing requests)
module rr_arbiter #(
    parameter int NUM_IN = 4,
    localparam int SEL_W = ($clog2(NUM_IN) > 0) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    always_comb begin
        logic             found;
        logic [SEL_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = SEL_W'((int'(ptr) + k) % NUM_IN);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: NUM_IN:1 valid/ready stream multiplexer with internal
// round-robin arbitration and one registered output stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : per-channel handshake (at most one in_ready high)
//   in_data             : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_last             : last beat of packet (only with STREAM_MUX_LOCK_EN)
//   out_valid/out_ready : downstream handshake
//   out_data, out_sel   : registered beat and the channel it came from
// Optional feature macro: STREAM_MUX_LOCK_EN keeps the grant on one channel
// from its first non-last beat until its last beat.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = ($clog2(NUM_IN) > 0) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last,
`endif
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] ch_data [NUM_IN];

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    outreg_state_e    out_state_reg, out_state_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [SEL_W-1:0] out_sel_reg, out_sel_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;

    logic [NUM_IN-1:0] arb_grant;
    logic [SEL_W-1:0]  arb_idx;
    logic [NUM_IN-1:0] grant_oh;
    logic [SEL_W-1:0]  grant_idx;
    logic              load;
    logic              xfer;

    rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Register can accept when empty, or when its current beat leaves this cycle.
    assign load = (out_state_reg == EMPTY) || out_ready;

`ifdef STREAM_MUX_LOCK_EN
    lock_state_e      lock_state_reg, lock_state_next;
    logic [SEL_W-1:0] owner_reg, owner_next;

    // While locked the owner holds the grant even when idle, so no other
    // channel can slip a beat into the middle of its packet.
    always_comb begin
        grant_oh  = arb_grant;
        grant_idx = arb_idx;
        if (lock_state_reg == LOCKED) begin
            grant_oh  = NUM_IN'(1) << owner_reg;
            grant_idx = owner_reg;
        end
    end
`else
    assign grant_oh  = arb_grant;
    assign grant_idx = arb_idx;
`endif

    assign in_ready  = (load && !rst) ? grant_oh : '0;
    assign xfer      = |(in_valid & in_ready);
    assign out_valid = (out_state_reg == FULL);
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

    always_comb begin
        out_state_next = out_state_reg;
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        ptr_next       = ptr_reg;
`ifdef STREAM_MUX_LOCK_EN
        lock_state_next = lock_state_reg;
        owner_next      = owner_reg;
`endif
        if (xfer) begin
            out_state_next = FULL;
            out_data_next  = ch_data[grant_idx];
            out_sel_next   = grant_idx;
`ifdef STREAM_MUX_LOCK_EN
            if (lock_state_reg == UNLOCKED) begin
                ptr_next = SEL_W'(next_ptr(int'(grant_idx), NUM_IN));
                if (!in_last[grant_idx]) begin
                    lock_state_next = LOCKED;
                    owner_next      = grant_idx;
                end
            end else if (in_last[owner_reg]) begin
                lock_state_next = UNLOCKED;
                ptr_next        = SEL_W'(next_ptr(int'(owner_reg), NUM_IN));
            end
`else
            ptr_next = SEL_W'(next_ptr(int'(grant_idx), NUM_IN));
`endif
        end else if (out_ready) begin
            out_state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_reg <= EMPTY;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            ptr_reg       <= '0;
`ifdef STREAM_MUX_LOCK_EN
            lock_state_reg <= UNLOCKED;
            owner_reg      <= '0;
`endif
        end else begin
            out_state_reg <= out_state_next;
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            ptr_reg       <= ptr_next;
`ifdef STREAM_MUX_LOCK_EN
            lock_state_reg <= lock_state_next;
            owner_reg      <= owner_next;
`endif
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        in_valid = '0;
    logic [127:0]      in_data = '0;
    logic [3:0]        in_ready;
    logic [3:0]        in_last = '0;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [1:0]        out_sel;
    logic              out_ready = 1'b0;

    logic [31:0] chd [4];
    exp_t        sb [$];
    logic        tb_full = 1'b0;
    logic [1:0]  last_sel = '0;
    logic [31:0] last_data = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag, input logic ordy);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = ordy;
        in_data   = {chd[3], chd[2], chd[1], chd[0]};
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, " out_sel"}, 32'(out_sel), 32'h0);
        chk({tag, " out_data"}, out_data, 32'h0);
        $display("txn %s: reset applied", tag);
        tb_full   = 1'b0;
        last_sel  = '0;
        last_data = '0;
        sb.delete();
        rst      = 1'b0;
        in_valid = '0;
    endtask

    task automatic cyc(input string tag, input logic [3:0] v, input logic ordy,
                       input logic [3:0] erdy, input logic [3:0] last);
        exp_t e;
        logic pushed;
        e = '0;
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        in_last   = last;
        in_data   = {chd[3], chd[2], chd[1], chd[0]};
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(erdy));
        pushed = 1'b0;
        if (|(v & erdy)) begin
            for (int i = 0; i < 4; i++) begin
                if (erdy[i]) begin
                    e.sel  = 2'(i);
                    e.data = chd[i];
                end
            end
            sb.push_back(e);
            pushed = 1'b1;
        end
        @(posedge clk);
        #1;
        if (pushed) begin
            tb_full = 1'b1;
            e = sb.pop_front();
            chk({tag, " out_valid"}, 32'(out_valid), 32'h1);
            chk({tag, " out_sel"}, 32'(out_sel), 32'(e.sel));
            chk({tag, " out_data"}, out_data, e.data);
            last_sel  = e.sel;
            last_data = e.data;
            $display("txn %s: beat ch%0d data=%h", tag, e.sel, e.data);
        end else begin
            if (ordy) tb_full = 1'b0;
            chk({tag, " out_valid"}, 32'(out_valid), 32'(tb_full));
            chk({tag, " out_sel hold"}, 32'(out_sel), 32'(last_sel));
            chk({tag, " out_data hold"}, out_data, last_data);
            $display("txn %s: no transfer, out_valid=%0d", tag, out_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) chd[i] = 32'hA0 + 32'(i);

        do_reset("reset", 1'b1);
        for (int k = 0; k < 5; k++) cyc("idle", 4'b0000, 1'b1, 4'b0000, 4'hF);

        // all channels requesting: grants rotate 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++)
            cyc("fair", 4'b1111, 1'b1, 4'(1 << (k % 4)), 4'hF);

        // single requester then downstream stall
        chd[2] = 32'h55;
        cyc("ch2", 4'b0100, 1'b1, 4'b0100, 4'hF);
        chd[2] = 32'h56;
        for (int k = 0; k < 3; k++) cyc("stall", 4'b0100, 1'b0, 4'b0000, 4'hF);
        cyc("unstall", 4'b0100, 1'b1, 4'b0100, 4'hF);

        // ptr is 3 now: ch3 first, then wrap to ch1
        chd[1] = 32'h11;
        chd[3] = 32'h33;
        cyc("wrap3", 4'b1010, 1'b1, 4'b1000, 4'hF);
        cyc("wrap1", 4'b1010, 1'b1, 4'b0010, 4'hF);

        // reset while a stalled beat is held; it must never appear
        chd[0] = 32'hDEAD;
        cyc("pre_rst", 4'b0001, 1'b1, 4'b0001, 4'hF);
        cyc("hold", 4'b0000, 1'b0, 4'b0000, 4'hF);
        do_reset("mid_rst", 1'b0);
        chd[0] = 32'hB0;
        cyc("post_rst", 4'b1111, 1'b1, 4'b0001, 4'hF);
        cyc("drain", 4'b0000, 1'b1, 4'b0000, 4'hF);

`ifdef STREAM_MUX_LOCK_EN
        // ptr is 1: ch1 packet of 3 beats locks out ch0 and ch2
        chd[0] = 32'hC0;
        chd[2] = 32'hC2;
        chd[1] = 32'h101;
        cyc("lock_b1", 4'b0111, 1'b1, 4'b0010, 4'b0000);
        cyc("lock_idle", 4'b0101, 1'b1, 4'b0010, 4'b0000);
        chd[1] = 32'h102;
        cyc("lock_b2", 4'b0111, 1'b1, 4'b0010, 4'b0000);
        chd[1] = 32'h103;
        cyc("lock_b3", 4'b0111, 1'b1, 4'b0010, 4'b0010);
        cyc("unlock", 4'b0101, 1'b1, 4'b0100, 4'hF);
`endif

        chk("scoreboard empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
